// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and the sub-word store latch record for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_RMW_WRITE = 1'b1;

  localparam int IDX_LSB_DEF = 2;
  localparam int IDX_MSB_DEF = 11;

  // State captured in the first RMW cycle and replayed in the write cycle
  typedef struct packed {
    logic [1:0]  size;
    logic [1:0]  off;
    logic [31:0] old;
    logic [31:0] data;
  } rmw_t;

endpackage

// File: rtl/mem_stage_lsu_lane_unit.sv
// Combinational lane logic: misalign detection, load lane select/extend, sub-word store merge.
module lsu_lane_unit
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic        req_signed_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [31:0] ld_data_o,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (req_size_i)
      SZ_BYTE: misalign_o = 1'b0;
      SZ_HALF: misalign_o = req_off_i[0];
      SZ_WORD: misalign_o = |req_off_i;
      default: misalign_o = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel  = rdata_i[{req_off_i, 3'b000} +: 8];
    half_sel  = req_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = '0;
    if (!misalign_o) begin
      unique case (req_size_i)
        SZ_BYTE: ld_data_o = {{24{req_signed_i & byte_sel[7]}}, byte_sel};
        SZ_HALF: ld_data_o = {{16{req_signed_i & half_sel[15]}}, half_sel};
        default: ld_data_o = rdata_i;
      endcase
    end
  end

  always_comb begin
    merged_o = st_old_i;
    if (st_size_i == SZ_BYTE)
      merged_o[{st_off_i, 3'b000} +: 8] = st_data_i[7:0];
    else if (st_off_i[1])
      merged_o[31:16] = st_data_i[15:0];
    else
      merged_o[15:0] = st_data_i[15:0];
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word loads/stores direct, sub-word stores via a 2-cycle RMW.
// Optional perf counters (load/store/stall) enabled by LSU_PERF_CNT_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_LSB = IDX_LSB_DEF,
  parameter int IDX_MSB = IDX_MSB_DEF,
  parameter int RD_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [RD_W-1:0]   req_rd_i,
  input  logic              flush_i,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_rdata_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic              wb_load_o,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]       cnt_load_o,
  output logic [31:0]       cnt_store_o,
  output logic [31:0]       cnt_stall_o,
`endif
  output logic              wb_misalign_o
);

  logic [0:0]                  state_q, state_d;
  rmw_t                        rmw_q, rmw_d;
  logic [ADDR_W-1:IDX_MSB+1]   rmw_hi_q, rmw_hi_d;
  logic [IDX_MSB:IDX_LSB]      rmw_idx_q, rmw_idx_d;
  logic                        wb_valid_q, wb_valid_d, wb_load_q, wb_load_d;
  logic                        wb_mis_q, wb_mis_d;
  logic [DATA_W-1:0]           wb_rdata_q, wb_rdata_d;
  logic [RD_W-1:0]             wb_rd_q, wb_rd_d;

  logic        misalign, go, sub_st, st_done;
  logic [31:0] ld_data, merged;

  lsu_lane_unit u_lane (
    .req_size_i   (req_size_i),
    .req_off_i    (req_addr_i[1:0]),
    .req_signed_i (req_signed_i),
    .rdata_i      (dm_rdata_i),
    .misalign_o   (misalign),
    .ld_data_o    (ld_data),
    .st_size_i    (rmw_q.size),
    .st_off_i     (rmw_q.off),
    .st_old_i     (rmw_q.old),
    .st_data_i    (rmw_q.data),
    .merged_o     (merged)
  );

  assign go     = req_valid_i & ~flush_i;
  assign sub_st = req_we_i & ((req_size_i == SZ_BYTE) | (req_size_i == SZ_HALF)) & ~misalign;

  always_comb begin
    state_d    = state_q;
    rmw_d      = rmw_q;
    rmw_hi_d   = rmw_hi_q;
    rmw_idx_d  = rmw_idx_q;
    req_ready_o = 1'b1;
    dm_we_o    = 1'b0;
    dm_addr_o  = {req_addr_i[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
    dm_wdata_o = req_wdata_i;
    wb_valid_d = 1'b0;
    wb_load_d  = 1'b0;
    wb_mis_d   = 1'b0;
    wb_rdata_d = '0;
    wb_rd_d    = '0;
    st_done    = 1'b0;
    if (state_q == ST_IDLE) begin
      req_ready_o = ~(go & sub_st);
      if (go) begin
        if (misalign) begin
          wb_valid_d = 1'b1;
          wb_mis_d   = 1'b1;
          wb_load_d  = ~req_we_i;
          wb_rd_d    = req_we_i ? '0 : req_rd_i;
        end else if (!req_we_i) begin
          wb_valid_d = 1'b1;
          wb_load_d  = 1'b1;
          wb_rdata_d = ld_data;
          wb_rd_d    = req_rd_i;
        end else if (!sub_st) begin
          dm_we_o    = 1'b1;
          wb_valid_d = 1'b1;
          st_done    = 1'b1;
        end else begin
          rmw_d     = '{size: req_size_i, off: req_addr_i[1:0], old: dm_rdata_i, data: req_wdata_i};
          rmw_hi_d  = req_addr_i[ADDR_W-1:IDX_MSB+1];
          rmw_idx_d = req_addr_i[IDX_MSB:IDX_LSB];
          state_d   = ST_RMW_WRITE;
        end
      end
    end else begin
      // Live request port is ignored here; upstream data was captured on entry
      req_ready_o = 1'b0;
      dm_addr_o   = {rmw_hi_q, rmw_idx_q, {IDX_LSB{1'b0}}};
      dm_wdata_o  = merged;
      dm_we_o     = ~flush_i;
      wb_valid_d  = ~flush_i;
      st_done     = ~flush_i;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rmw_q      <= '0;
      rmw_hi_q   <= '0;
      rmw_idx_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      rmw_q      <= rmw_d;
      rmw_hi_q   <= rmw_hi_d;
      rmw_idx_q  <= rmw_idx_d;
      wb_valid_q <= wb_valid_d;
      wb_load_q  <= wb_load_d;
      wb_mis_q   <= wb_mis_d;
      wb_rdata_q <= wb_rdata_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_rdata_o    = wb_rdata_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_load_o     = wb_load_q;
  assign wb_misalign_o = wb_mis_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_load_q, cnt_store_q, cnt_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) & go & ~req_we_i) cnt_load_q <= cnt_load_q + 32'd1;
      if (st_done)                                cnt_store_q <= cnt_store_q + 32'd1;
      if (req_valid_i & ~req_ready_o)             cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign cnt_load_o  = cnt_load_q;
  assign cnt_store_o = cnt_store_q;
  assign cnt_stall_o = cnt_stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a behavioural word memory (comb read, posedge write).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_load, wb_misalign;
  logic [31:0] wb_rdata;
  logic [4:0]  wb_rd;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_load, cnt_store, cnt_stall;
`endif

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;

  mem_stage_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .flush_i(flush),
    .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_rdata_i(dm_rdata),
    .wb_valid_o(wb_valid), .wb_rdata_o(wb_rdata), .wb_rd_o(wb_rd), .wb_load_o(wb_load),
`ifdef LSU_PERF_CNT_EN
    .cnt_load_o(cnt_load), .cnt_store_o(cnt_store), .cnt_stall_o(cnt_stall),
`endif
    .wb_misalign_o(wb_misalign)
  );

  // Drive a request at the falling edge, then let comb outputs settle
  task automatic drv(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                     input logic fl);
    @(negedge clk);
    req_valid = v; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d; req_rd = rd; flush = fl;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0; flush = 0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
    checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL rst_wb_rdata: got %h exp 0", wb_rdata); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_dm_we: got %b exp 0", dm_we); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_byte();
    drv(1, 0, 2'b00, 1, 32'h11, 0, 5'd7, 0);
    checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL ldb_dm_addr: got %h exp 10", dm_addr); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL ldb_dm_we: got %b exp 0", dm_we); end
    edge_settle();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ldb_wb_valid: got %b exp 1", wb_valid); end
    checks++; if (wb_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL ldb_signed: got %h exp ffffffaa", wb_rdata); end
    checks++; if (wb_load !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL ldb_load_rd: got %b/%0d exp 1/7", wb_load, wb_rd); end
    drv(1, 0, 2'b00, 0, 32'h11, 0, 5'd7, 0);
    edge_settle();
    checks++; if (wb_rdata !== 32'h000000AA) begin errors++; $display("FAIL ldb_unsigned: got %h exp 000000aa", wb_rdata); end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    edge_settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_wb_valid: got %b exp 0", wb_valid); end
  endtask

  task automatic test_rmw_half();
    drv(1, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw_ready0: got %b exp 0", req_ready); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rmw_read_we: got %b exp 0", dm_we); end
    edge_settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmw_wb_early: got %b exp 0", wb_valid); end
    drv(0, 0, 0, 0, 32'h40, 32'hCAFECAFE, 0, 0);
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL rmw_we: got %b exp 1", dm_we); end
    checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL rmw_addr: got %h exp 10", dm_addr); end
    checks++; if (dm_wdata !== 32'h1234AABB) begin errors++; $display("FAIL rmw_wdata: got %h exp 1234aabb", dm_wdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw_ready1: got %b exp 0", req_ready); end
    edge_settle();
    checks++; if (wb_valid !== 1'b1 || wb_load !== 1'b0) begin errors++; $display("FAIL rmw_wb: got %b/%b exp 1/0", wb_valid, wb_load); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready_back: got %b exp 1", req_ready); end
    drv(1, 0, 2'b10, 0, 32'h10, 0, 5'd3, 0);
    edge_settle();
    checks++; if (wb_rdata !== 32'h1234AABB) begin errors++; $display("FAIL rmw_readback: got %h exp 1234aabb", wb_rdata); end
  endtask

  task automatic test_word_store();
    drv(1, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0);
    checks++; if (dm_we !== 1'b1 || dm_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_we_data: got %b/%h exp 1/deadbeef", dm_we, dm_wdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b exp 1", req_ready); end
    edge_settle();
    checks++; if (wb_valid !== 1'b1 || wb_load !== 1'b0) begin errors++; $display("FAIL sw_wb: got %b/%b exp 1/0", wb_valid, wb_load); end
    checks++; if (mem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h exp deadbeef", mem[8]); end
  endtask

  task automatic test_misalign();
    drv(1, 0, 2'b01, 1, 32'h13, 0, 5'd4, 0);
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL mis_lh_we: got %b exp 0", dm_we); end
    edge_settle();
    checks++; if (wb_misalign !== 1'b1 || wb_rdata !== 32'h0 || wb_valid !== 1'b1) begin errors++; $display("FAIL mis_lh_wb: got mis=%b d=%h v=%b exp 1/0/1", wb_misalign, wb_rdata, wb_valid); end
    drv(1, 1, 2'b10, 0, 32'h22, 32'h01020304, 0, 0);
    checks++; if (dm_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mis_sw: got we=%b rdy=%b exp 0/1", dm_we, req_ready); end
    edge_settle();
    checks++; if (wb_misalign !== 1'b1) begin errors++; $display("FAIL mis_sw_flag: got %b exp 1", wb_misalign); end
    checks++; if (mem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_sw_mem: got %h exp deadbeef", mem[8]); end
    drv(1, 0, 2'b11, 0, 32'h10, 0, 5'd1, 0);
    edge_settle();
    checks++; if (wb_misalign !== 1'b1 || wb_rdata !== 32'h0) begin errors++; $display("FAIL mis_rsv: got %b/%h exp 1/0", wb_misalign, wb_rdata); end
    drv(1, 0, 2'b10, 0, 32'h10, 0, 5'd1, 0);
    edge_settle();
    checks++; if (wb_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b exp 0", wb_misalign); end
  endtask

  task automatic test_flush_reset();
    mem[12] = 32'h11223344;
    drv(1, 0, 2'b10, 0, 32'h30, 0, 5'd2, 1);
    edge_settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_idle_ld: got %b exp 0", wb_valid); end
    drv(1, 1, 2'b00, 0, 32'h31, 32'h55, 0, 1);
    checks++; if (dm_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL fl_idle_st: got we=%b rdy=%b exp 0/1", dm_we, req_ready); end
    edge_settle();
    drv(1, 1, 2'b00, 0, 32'h31, 32'h55, 0, 0);
    edge_settle();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL fl_rmw_we: got %b exp 0", dm_we); end
    edge_settle();
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b0 && 1'b0) begin errors++; $display("FAIL fl_rmw_wb: got %b exp 0", wb_valid); end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (req_ready !== 1'b1 || dm_we !== 1'b0) begin errors++; $display("FAIL fl_rmw_idle: got rdy=%b we=%b exp 1/0", req_ready, dm_we); end
    checks++; if (mem[12] !== 32'h11223344) begin errors++; $display("FAIL fl_mem: got %h exp 11223344", mem[12]); end
    drv(1, 1, 2'b00, 0, 32'h31, 32'h55, 0, 0);
    edge_settle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL rst_rmw_pre: got %b exp 1", dm_we); end
    rst = 1'b1; #1;
    checks++; if (dm_we !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_rmw: got we=%b rdy=%b v=%b exp 0/1/0", dm_we, req_ready, wb_valid); end
    edge_settle();
    checks++; if (mem[12] !== 32'h11223344) begin errors++; $display("FAIL rst_rmw_mem: got %h exp 11223344", mem[12]); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drv(1, 1, 2'b00, 0, 32'h31, 32'h55, 0, 0);
    edge_settle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    edge_settle();
    drv(1, 0, 2'b00, 0, 32'h31, 0, 5'd9, 0);
    edge_settle();
    checks++; if (wb_rdata !== 32'h00000055) begin errors++; $display("FAIL b2b_lb: got %h exp 00000055", wb_rdata); end
    checks++; if (mem[12] !== 32'h11225544) begin errors++; $display("FAIL b2b_mem: got %h exp 11225544", mem[12]); end
    drv(1, 0, 2'b01, 1, 32'h12, 0, 5'd9, 0);
    edge_settle();
    checks++; if (wb_rdata !== 32'h00001234) begin errors++; $display("FAIL b2b_lh: got %h exp 00001234", wb_rdata); end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf_cnt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    checks++; if (cnt_load !== 0 || cnt_store !== 0 || cnt_stall !== 0) begin errors++; $display("FAIL cnt_rst: got %0d/%0d/%0d exp 0/0/0", cnt_load, cnt_store, cnt_stall); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2'b10, 0, 32'h10, 0, 5'd1, 0);
      edge_settle();
    end
    for (int i = 0; i < 2; i++) begin
      drv(1, 1, 2'b00, 0, 32'h40 + i, 32'hA5, 0, 0);
      edge_settle();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      edge_settle();
    end
    drv(1, 1, 2'b10, 0, 32'h44, 32'h77, 0, 0);
    edge_settle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    edge_settle();
    checks++; if (cnt_load !== 32'd3) begin errors++; $display("FAIL cnt_load: got %0d exp 3", cnt_load); end
    checks++; if (cnt_store !== 32'd3) begin errors++; $display("FAIL cnt_store: got %0d exp 3", cnt_store); end
    checks++; if (cnt_stall !== 32'd2) begin errors++; $display("FAIL cnt_stall: got %0d exp 2", cnt_stall); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    test_reset();
    test_load_byte();
    test_rmw_half();
    test_word_store();
    test_misalign();
    test_flush_reset();
    test_back_to_back();
`ifdef LSU_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM pipeline stage.
- Sits between the EX/MEM pipeline register (upstream) and the word-wide data memory (downstream). The data memory has a combinational read, a registered write on clk, and word index taken from address bits [11:2].
- Converts byte/halfword/word accesses into word accesses. Sub-word stores use a two-cycle read-modify-write (RMW).
- Sign/zero-extends loads, flags misaligned accesses, and registers results into the MEM/WB interface. Asserts a stall toward upstream during RMW.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- IDX_LSB, 2, lowest word-index address bit.
- IDX_MSB, 11, highest word-index address bit (1024 words).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  EX/MEM holds a memory instruction.
- req_ready  out  1  request accepted this cycle; 0 = stall upstream.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  load sign-extend (1) or zero-extend (0).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_rd  in  RD_W  load destination register.
- flush  in  1  discard request/accepted op (pipeline flush).
- dm_we  out  1  data memory write enable.
- dm_addr  out  ADDR_W  data memory address, low 2 bits forced 0.
- dm_wdata  out  DATA_W  data memory write data.
- dm_rdata  in  DATA_W  data memory combinational read data.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rdata  out  DATA_W  extended load data; 0 for stores.
- wb_rd  out  RD_W  destination register.
- wb_load  out  1  entry is a load (register write needed).
- wb_misalign  out  1  access was misaligned/reserved size; no memory effect.

Behaviour:
- Reset: state IDLE; all wb_* outputs 0; dm_we 0; internal RMW latches 0. Reset is asynchronous and takes effect mid-RMW with no memory write.
- Misalignment rule:
  - half requires addr[0]=0;
  - word requires addr[1:0]=00;
  - size 11 is always misaligned.
  - A misaligned access never asserts dm_we. The load result is 0 and wb_misalign=1.
- State IDLE:
  - req_ready = !(req_valid & req_we & size∈{00,01} & aligned & !flush).
  - Load: dm_addr = {addr[31:2],00}. The lane is selected by addr[1:0] (byte) or addr[1] (half) and extended per req_signed. Result is registered: wb_* are valid the cycle after acceptance (latency 1).
  - Word store: dm_we=1 the same cycle, dm_wdata=req_wdata. The wb entry has wb_valid=1, wb_load=0.
  - Sub-word aligned store: latch the full dm_rdata word, address, data, size and byte offset, then go to RMW_WRITE. The wb entry is not produced this cycle (wb_valid=0 next cycle).
- State RMW_WRITE:
  - req_ready=0.
  - Drive dm_we=1 to the latched address with the merged word: latched old word with the target byte/half lanes replaced by req_wdata[7:0]/[15:0]. The latched data is used; the live port is ignored.
  - Register the wb entry (wb_valid=1, wb_load=0) and return to IDLE.
- Latencies: total store latency 2 cycles; one stall cycle inserted upstream.
- flush:
  - In IDLE it suppresses dm_we and forces wb_valid=0 next cycle.
  - In RMW_WRITE it aborts: no write, return to IDLE, wb_valid=0.
- req_valid=0 in IDLE: wb_valid=0 next cycle, dm_we=0.
- Address bits above IDX_MSB are passed through unchanged. Aliasing is the memory's concern.
- Back-to-back store then load to the same word: the load issues the cycle after RMW_WRITE, so the memory already holds the merged word. No forwarding is needed.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined:
  - Adds three 32-bit outputs: cnt_load, cnt_store, cnt_stall.
  - Each counts on accepted non-flushed loads, completed stores, and cycles with req_valid & !req_ready.
  - Counters are cleared by rst and wrap at 2^32.
- When undefined: the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings ST_IDLE, ST_RMW_WRITE;
  - the IDX_LSB/IDX_MSB defaults.
- One natural sub-module, lsu_lane_unit: purely combinational.
  - Load lane-select/extend.
  - Store byte/half merge.
  - Misalign detection.
  - Instantiated once; the FSM and registers stay in mem_stage_lsu.

Test Plan:
- Word at 0x10 = 0x8899AABB; byte load at 0x11 with signed=1 -> wb_rdata=0xFFFFFFAA, wb_valid=1 one cycle later. With signed=0 -> 0x000000AA.
- Half store 0x1234 to 0x12 over word 0x8899AABB -> req_ready=0 for one cycle, then dm_we=1 with dm_wdata=0x1234AABB at dm_addr=0x10. A subsequent word load returns 0x1234AABB.
- Word store 0xDEADBEEF to 0x20 -> dm_we=1 in the same cycle, req_ready stays 1, wb_valid=1 and wb_load=0 next cycle.
- Half load at 0x13 and word store to 0x22 -> no dm_we, wb_misalign=1, wb_rdata=0, memory unchanged.
- Byte store to 0x31; flush asserted in RMW_WRITE -> no dm_we, wb_valid=0, state IDLE. Repeat the store and assert rst mid-RMW instead -> outputs 0 immediately, no write.
- With LSU_PERF_CNT_EN defined: 3 loads + 2 byte stores + 1 word store -> cnt_load=3, cnt_store=3, cnt_stall=2.
